// File: rtl/cnn_dma_pkg.sv
// Shared types and constants for the CNN DMA responder.
package cnn_dma_pkg;

  typedef enum logic [1:0] {
    OpReadWin    = 2'd0,
    OpWriteWord  = 2'd1,
    OpLoadFilter = 2'd2,
    OpLoadBias   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWr,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned WIN_WORDS  = 25;
  localparam int unsigned BIAS_MAX   = 120;
  localparam int unsigned MEM_RD_LAT = 1;

endpackage

// File: rtl/cnn_dma_responder_if.sv
// Controller/RAM/filter-buffer signal bundle seen by the DMA responder.
interface cnn_dma_responder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WIN    = 5
) ();
    logic                      start;
    logic [1:0]                op;
    logic [ADDR_W-1:0]         start_address;
    logic [ADDR_W-1:0]         offset;
    logic [7:0]                filter_number;
    logic [DATA_W-1:0]         wr_data;
    logic                      finish;
    logic [WIN*WIN*DATA_W-1:0] window_data;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      fb_we;
    logic                      fb_bias_sel;
    logic [6:0]                fb_index;
    logic [DATA_W-1:0]         fb_wdata;

    modport master (
        output start, op, start_address, offset, filter_number, wr_data, mem_rdata,
        input  finish, window_data, mem_en, mem_we, mem_addr, mem_wdata,
        input  fb_we, fb_bias_sel, fb_index, fb_wdata
    );

    modport slave (
        input  start, op, start_address, offset, filter_number, wr_data, mem_rdata,
        output finish, window_data, mem_en, mem_we, mem_addr, mem_wdata,
        output fb_we, fb_bias_sel, fb_index, fb_wdata
    );
endinterface

// File: rtl/dma_addr_gen.sv
// Row/column/linear counters producing base + r*stride + c without a multiplier;
// loads reuse it with stride=WIN so r*WIN+c equals the linear index.
module dma_addr_gen #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WIN    = 5,
    parameter int unsigned IDX_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [IDX_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              last_issue,
    output logic [IDX_W-1:0]  cap_idx
);
    localparam int unsigned CW = $clog2(WIN);

    logic [ADDR_W-1:0] row_q, stride_q;
    logic [IDX_W-1:0]  count_q, idx_q, cap_idx_q;
    logic [CW-1:0]     col_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q     <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            cap_idx_q <= '0;
            col_q     <= '0;
        end else if (load) begin
            row_q    <= base;
            stride_q <= stride;
            count_q  <= count;
            idx_q    <= '0;
            col_q    <= '0;
        end else if (step) begin
            cap_idx_q <= idx_q;
            idx_q     <= idx_q + IDX_W'(1);
            if (col_q == CW'(WIN - 1)) begin
                col_q <= '0;
                row_q <= row_q + stride_q;
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    assign addr       = row_q + ADDR_W'(col_q);
    assign last_issue = (idx_q == IDX_W'(count_q - IDX_W'(1)));
    assign cap_idx    = cap_idx_q;
endmodule

// File: rtl/cnn_dma_responder.sv
// Memory-side DMA responder: runs one window read, word write, filter load or bias
// load per four-phase start/finish handshake against a 1-cycle-latency word RAM.
module cnn_dma_responder #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned WIN      = 5,
    parameter int unsigned BIAS_MAX = 120
) (
    input logic               clk,
    input logic               reset,
    cnn_dma_responder_if.slave bus
);
    import cnn_dma_pkg::*;

    localparam int unsigned IDX_W  = 7;
    localparam int unsigned SLOT_W = $clog2(WIN * WIN);

    state_e                          state_q, state_d;
    op_e                             op_q, op_in;
    logic [ADDR_W-1:0]               wr_addr_q;
    logic [DATA_W-1:0]               wr_data_q;
    logic                            cap_valid_q;
    logic [WIN*WIN-1:0][DATA_W-1:0]  window_q;
    logic                            accept, last_issue;
    logic [ADDR_W-1:0]               base_in, stride_in, gen_addr;
    logic [IDX_W-1:0]                count_in, bias_n, cap_idx;

    assign op_in  = op_e'(bus.op);
    assign accept = (state_q == StIdle) && bus.start;
    assign bias_n = (bus.offset > ADDR_W'(BIAS_MAX)) ? IDX_W'(BIAS_MAX) : bus.offset[IDX_W-1:0];

    always_comb begin
        base_in   = bus.start_address;
        stride_in = ADDR_W'(WIN);
        count_in  = IDX_W'(WIN * WIN);
        unique case (op_in)
            OpReadWin:    stride_in = bus.offset;
            OpLoadFilter: base_in = bus.start_address
                                    + ADDR_W'(bus.filter_number) * ADDR_W'(WIN * WIN);
            OpLoadBias:   count_in = bias_n;
            default:      ;
        endcase
    end

    dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .WIN    (WIN),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .step       (state_q == StIssue),
        .base       (base_in),
        .stride     (stride_in),
        .count      (count_in),
        .addr       (gen_addr),
        .last_issue (last_issue),
        .cap_idx    (cap_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (op_in == OpWriteWord)                    state_d = StWr;
                    else if (op_in == OpLoadBias && bias_n == '0) state_d = StDone;
                    else                                          state_d = StIssue;
                end
            end
            StIssue: if (last_issue) state_d = StDrain;
            StWr:    state_d = StDone;
            StDrain: state_d = StDone;
            StDone:  if (!bus.start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.finish      = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fb_we       = 1'b0;
        bus.fb_bias_sel = 1'b0;
        bus.fb_index    = '0;
        bus.fb_wdata    = '0;
        unique case (state_q)
            StIssue: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = gen_addr;
            end
            StWr: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = wr_addr_q;
                bus.mem_wdata = wr_data_q;
            end
            StDone:  bus.finish = 1'b1;
            default: ;
        endcase
        // Capture runs one cycle behind issue, so it overlaps ISSUE and DRAIN.
        if (cap_valid_q && op_q != OpReadWin) begin
            bus.fb_we       = 1'b1;
            bus.fb_bias_sel = (op_q == OpLoadBias);
            bus.fb_index    = cap_idx;
            bus.fb_wdata    = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OpReadWin;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cap_valid_q <= 1'b0;
            window_q    <= '0;
        end else begin
            cap_valid_q <= (state_q == StIssue);
            if (accept) begin
                op_q      <= op_in;
                wr_addr_q <= bus.start_address;
                wr_data_q <= bus.wr_data;
            end
            if (cap_valid_q && op_q == OpReadWin && cap_idx < IDX_W'(WIN * WIN)) begin
                window_q[cap_idx[SLOT_W-1:0]] <= bus.mem_rdata;
            end
        end
    end

    assign bus.window_data = window_q;
endmodule

// File: tb/tb_cnn_dma_responder.sv
// Bench: directed + random commands against a RAM model and an address/latency reference.
module tb_cnn_dma_responder;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int W  = 5;

    typedef struct {
        logic        sel;
        logic [6:0]  idx;
        logic [15:0] data;
    } fbw_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cnn_dma_responder_if #(.DATA_W(DW), .ADDR_W(AW), .WIN(W)) dif ();

    cnn_dma_responder #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .WIN      (W),
        .BIAS_MAX (120)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    logic [15:0] ram [0:65535];
    logic [15:0] rdata_q = '0;
    logic        rq_en = 1'b0, rq_we = 1'b0;
    logic [15:0] rq_addr = '0, rq_wdata = '0;
    assign dif.mem_rdata = rdata_q;

    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    fbw_t        fb_q[$];
    int          bad = 0;
    logic [15:0] exp_win [25];
    int          tests = 0;
    int          fails = 0;

    // Requests are sampled mid-cycle and acted on at the next edge, like a real sync RAM.
    always @(negedge clk) begin
        rq_en    = dif.mem_en;
        rq_we    = dif.mem_we;
        rq_addr  = dif.mem_addr;
        rq_wdata = dif.mem_wdata;
        if (dif.mem_en && !dif.mem_we) rd_q.push_back(dif.mem_addr);
        if (dif.mem_en && dif.mem_we) begin
            wa_q.push_back(dif.mem_addr);
            wd_q.push_back(dif.mem_wdata);
        end
        if (dif.fb_we) fb_q.push_back('{dif.fb_bias_sel, dif.fb_index, dif.fb_wdata});
        if ((dif.finish || !reset) && (dif.mem_en || dif.fb_we)) bad++;
    end

    always @(posedge clk) begin
        if (rq_en) begin
            if (rq_we) ram[rq_addr] = rq_wdata;
            else       rdata_q <= ram[rq_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_window(input string tag);
        for (int k = 0; k < 25; k++)
            check($sformatf("%s win[%0d]", tag, k), 32'(dif.window_data[k*16 +: 16]), 32'(exp_win[k]));
    endtask

    task automatic run_cmd(input int op, input logic [15:0] sa, input logic [15:0] off,
                           input logic [7:0] fn, input logic [15:0] wd, input int hold,
                           input int drop_at, input string tag);
        logic [15:0] ea[$];
        int n, exp_lat, lat, held, nrd_hold;
        case (op)
            0: for (int r = 0; r < 5; r++)
                   for (int c = 0; c < 5; c++) ea.push_back(16'(sa + r * off + c));
            2: for (int k = 0; k < 25; k++) ea.push_back(16'(sa + fn * 25 + k));
            3: for (int k = 0; k < ((off > 120) ? 120 : int'(off)); k++) ea.push_back(16'(sa + k));
            default: ;
        endcase
        n = ea.size();
        exp_lat = (op == 1) ? 2 : ((n == 0) ? 1 : n + 2);
        rd_q.delete(); wa_q.delete(); wd_q.delete(); fb_q.delete();

        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'(op); dif.start_address = sa; dif.offset = off;
        dif.filter_number = fn; dif.wr_data = wd;
        @(posedge clk); #1;
        lat = 1;
        while (!dif.finish && lat < 400) begin
            if (drop_at != 0 && lat == drop_at) dif.start = 1'b0;
            dif.op = 2'($urandom); dif.start_address = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        if (drop_at == 0) begin
            held = 1;
            nrd_hold = rd_q.size();
            repeat (hold) begin
                @(posedge clk); #1;
                if (!dif.finish) held = 0;
            end
            if (hold > 0) begin
                check({tag, " finish held"}, held, 1);
                check({tag, " no restart"}, rd_q.size(), nrd_hold);
            end
            dif.start = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, " finish drop"}, dif.finish, 0);
        @(negedge clk);

        check({tag, " reads"}, rd_q.size(), n);
        for (int k = 0; k < n && k < rd_q.size(); k++)
            check($sformatf("%s addr[%0d]", tag, k), rd_q[k], ea[k]);
        if (op == 0) for (int k = 0; k < 25; k++) exp_win[k] = ram[ea[k]];
        check_window(tag);
        check({tag, " fb writes"}, fb_q.size(), (op >= 2) ? n : 0);
        for (int k = 0; k < n && k < fb_q.size() && op >= 2; k++) begin
            check($sformatf("%s fb idx[%0d]", tag, k), fb_q[k].idx, k);
            check($sformatf("%s fb data[%0d]", tag, k), fb_q[k].data, ram[ea[k]]);
            check($sformatf("%s fb sel[%0d]", tag, k), fb_q[k].sel, (op == 3) ? 1 : 0);
        end
        check({tag, " mem writes"}, wa_q.size(), (op == 1) ? 1 : 0);
        if (op == 1 && wa_q.size() > 0) begin
            check({tag, " wr addr"}, wa_q[0], sa);
            check({tag, " wr data"}, wd_q[0], wd);
            check({tag, " ram readback"}, ram[sa], wd);
        end
    endtask

    initial begin
        int nfb;
        logic [7:0] rfn;
        dif.start = 1'b0; dif.op = '0; dif.start_address = '0; dif.offset = '0;
        dif.filter_number = '0; dif.wr_data = '0;
        for (int a = 0; a < 65536; a++) ram[a] = 16'(a);
        for (int k = 0; k < 25; k++) exp_win[k] = '0;

        repeat (3) @(negedge clk);
        check("rst finish", dif.finish, 0);
        check("rst mem_en", dif.mem_en, 0);
        check("rst fb_we", dif.fb_we, 0);
        check("rst mem_addr", dif.mem_addr, 0);
        check_window("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(0, 16'd100, 16'd32, 8'd0, 16'd0, 0, 0, "rd_win");
        check("slot24", 32'(dif.window_data[24*16 +: 16]), 32'd232);
        run_cmd(1, 16'd56420, 16'd0, 8'd0, 16'hFFF3, 0, 0, "wr_word");
        run_cmd(2, 16'd0, 16'd0, 8'd5, 16'd0, 0, 0, "ld_filt");
        run_cmd(3, 16'd50550, 16'd6, 8'd0, 16'd0, 0, 0, "bias6");
        run_cmd(3, 16'd50550, 16'd0, 8'd0, 16'd0, 0, 0, "bias0");
        run_cmd(3, 16'd50550, 16'd200, 8'd0, 16'd0, 0, 0, "bias200");
        run_cmd(0, 16'd7, 16'd9, 8'd0, 16'd0, 10, 0, "hold");
        run_cmd(0, 16'd300, 16'd3, 8'd0, 16'd0, 0, 5, "drop");

        // Abort a filter load with an asynchronous reset mid-stream.
        @(negedge clk);
        dif.start = 1'b1; dif.op = 2'd2; dif.start_address = 16'd40; dif.filter_number = 8'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort finish", dif.finish, 0);
        check("abort mem_en", dif.mem_en, 0);
        check("abort fb_we", dif.fb_we, 0);
        check("abort fb_index", dif.fb_index, 0);
        check("abort fb_wdata", dif.fb_wdata, 0);
        check("abort mem_addr", dif.mem_addr, 0);
        for (int k = 0; k < 25; k++) exp_win[k] = '0;
        check_window("abort");
        nfb = fb_q.size();
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort no fb after", fb_q.size(), nfb);

        run_cmd(0, 16'hFFFE, 16'd1, 8'd0, 16'd0, 0, 0, "wrap");

        for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
        for (int i = 0; i < 10; i++) begin
            int rop;
            logic [15:0] roff;
            rop  = int'($urandom_range(0, 3));
            roff = (rop == 3) ? 16'($urandom_range(0, 130)) : 16'($urandom);
            rfn  = 8'($urandom);
            run_cmd(rop, 16'($urandom), roff, rfn, 16'($urandom),
                    int'($urandom_range(0, 3)), 0, $sformatf("rand%0d op%0d", i, rop));
        end

        check("no access in DONE/reset", bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
